// File: rtl/wino_pkg.sv
// wino_pkg: shared FSM states, lane-mode constants and tile/butterfly index helpers for wino_bdb_pipe
package wino_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic WINO_MODE_FULL = 1'b0;
  localparam logic WINO_MODE_DUAL = 1'b1;
  function automatic int elem_idx(input int r, input int c);
    return 4 * r + c;
  endfunction
  // Butterfly k of Bt: out0 = x0-x2, out1 = x1+x2, out2 = x2-x1, out3 = x1-x3
  function automatic int bf_a(input int k);
    return (k == 0) ? 0 : (k == 2) ? 2 : 1;
  endfunction
  function automatic int bf_b(input int k);
    return (k < 2) ? 2 : (k == 2) ? 1 : 3;
  endfunction
  function automatic logic bf_sub(input int k);
    return k != 1;
  endfunction
endpackage

// File: rtl/wino_lane_addsub.sv
// wino_lane_addsub: ELEM_W add/sub, optionally split into two ELEM_W/2 lanes; saturates when WINO_SAT_EN is defined
module wino_lane_addsub #(
  parameter int ELEM_W = 16
) (
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic              sub,
  input  logic              mode,
  output logic [ELEM_W-1:0] y
);
  localparam int H = ELEM_W / 2;
`ifdef WINO_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic [ELEM_W:0] f;
  logic [H:0] lo, hi;
  function automatic logic [ELEM_W-1:0] fit_f(input logic [ELEM_W:0] x);
    return (SAT && x[ELEM_W] != x[ELEM_W-1]) ? {x[ELEM_W], {(ELEM_W-1){~x[ELEM_W]}}} : x[ELEM_W-1:0];
  endfunction
  function automatic logic [H-1:0] fit_h(input logic [H:0] x);
    return (SAT && x[H] != x[H-1]) ? {x[H], {(H-1){~x[H]}}} : x[H-1:0];
  endfunction
  // One guard bit per lane keeps lanes independent and exposes overflow
  always_comb begin
    f  = sub ? {a[ELEM_W-1], a} - {b[ELEM_W-1], b} : {a[ELEM_W-1], a} + {b[ELEM_W-1], b};
    lo = sub ? {a[H-1], a[H-1:0]} - {b[H-1], b[H-1:0]} : {a[H-1], a[H-1:0]} + {b[H-1], b[H-1:0]};
    hi = sub ? {a[ELEM_W-1], a[ELEM_W-1:H]} - {b[ELEM_W-1], b[ELEM_W-1:H]}
             : {a[ELEM_W-1], a[ELEM_W-1:H]} + {b[ELEM_W-1], b[ELEM_W-1:H]};
    y  = mode ? {fit_h(hi), fit_h(lo)} : fit_f(f);
  end
endmodule

// File: rtl/wino_bdb_pipe.sv
// wino_bdb_pipe: streaming Winograd F(2x2,3x3) input transform V = Bt*d*B with job control and output FIFO
// Define WINO_SAT_EN for per-lane saturation instead of wrap-around.
module wino_bdb_pipe
  import wino_pkg::*;
#(
  parameter int ELEM_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     cfg_tiles,
  input  logic                 cfg_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*ELEM_W-1:0] in_tile,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*ELEM_W-1:0] out_tile,
  output logic                 busy,
  output logic                 done
);
  localparam int TW = 16 * ELEM_W;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] tiles_q, tiles_d, acc_q, acc_d, emit_q, emit_d;
  logic mode_q, mode_d, s1_valid_q, s1_valid_d;
  logic [TW-1:0] s1_q, s1_d, t_w, v_w;
  logic [TW-1:0] mem_q [FIFO_DEPTH];
  logic [TW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic in_fire, out_fire, last_in, last_out, dual;

  assign dual = mode_q == WINO_MODE_DUAL;

  // Stage 1 transforms columns of in_tile; stage 2 transforms rows of the registered result
  for (genvar i = 0; i < 4; i++) begin : g_k
    for (genvar j = 0; j < 4; j++) begin : g_l
      wino_lane_addsub #(.ELEM_W(ELEM_W)) u_s1 (
        .a   (in_tile[elem_idx(bf_a(i), j)*ELEM_W +: ELEM_W]),
        .b   (in_tile[elem_idx(bf_b(i), j)*ELEM_W +: ELEM_W]),
        .sub (bf_sub(i)),
        .mode(dual),
        .y   (t_w[elem_idx(i, j)*ELEM_W +: ELEM_W])
      );
      wino_lane_addsub #(.ELEM_W(ELEM_W)) u_s2 (
        .a   (s1_q[elem_idx(j, bf_a(i))*ELEM_W +: ELEM_W]),
        .b   (s1_q[elem_idx(j, bf_b(i))*ELEM_W +: ELEM_W]),
        .sub (bf_sub(i)),
        .mode(dual),
        .y   (v_w[elem_idx(j, i)*ELEM_W +: ELEM_W])
      );
    end
  end

  // Tiles in stage 1 count against FIFO space, so the FIFO can never overflow
  assign in_ready  = (state_q == RUN) && (acc_q < tiles_q) &&
                     ((CW+1)'(cnt_q) + (CW+1)'(s1_valid_q) < (CW+1)'(FIFO_DEPTH));
  assign out_valid = cnt_q != '0;
  assign out_tile  = mem_q[rd_q];
  assign busy      = state_q != IDLE;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_in   = acc_q == tiles_q - CNT_W'(1);
  assign last_out  = emit_q == tiles_q - CNT_W'(1);
  assign done      = (state_q == DRAIN) && ((tiles_q == '0) || (out_fire && last_out));

  always_comb begin
    state_d    = state_q;
    tiles_d    = tiles_q;
    mode_d     = mode_q;
    acc_d      = acc_q + CNT_W'(in_fire);
    emit_d     = emit_q + CNT_W'(out_fire);
    s1_valid_d = in_fire;
    s1_d       = in_fire ? t_w : s1_q;
    mem_d      = mem_q;
    if (s1_valid_q) mem_d[wr_q] = v_w;
    wr_d       = !s1_valid_q ? wr_q : (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + PW'(1);
    rd_d       = !out_fire ? rd_q : (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + PW'(1);
    cnt_d      = cnt_q + CW'(s1_valid_q) - CW'(out_fire);
    case (state_q)
      IDLE: if (start) begin
        tiles_d = cfg_tiles;
        mode_d  = cfg_mode;
        acc_d   = '0;
        emit_d  = '0;
        state_d = (cfg_tiles == '0) ? DRAIN : RUN;
      end
      RUN:     state_d = (in_fire && last_in) ? DRAIN : RUN;
      DRAIN:   state_d = done ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tiles_q    <= '0;
      mode_q     <= WINO_MODE_FULL;
      acc_q      <= '0;
      emit_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tiles_q    <= tiles_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      emit_q     <= emit_d;
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: doc/wino_bdb_pipe.md
# wino_bdb_pipe

Pipelined, parametrised Winograd F(2x2,3x3) input-transform engine computing V = Bᵀ·d·B on 4x4 activation tiles. It sits between the activation tile buffer and the element-wise multiply array. It replaces the single-shot transform FSM with a streaming engine that has:
- valid/ready handshakes on both sides,
- a job-level tile counter with start/done control,
- selectable sub-word lane packing,
- an output FIFO that absorbs backpressure.

## Interface
- ELEM_W, 16, element width in bits; must be even and ≥ 8
- FIFO_DEPTH, 4, output FIFO entries; minimum 2
- CNT_W, 16, width of the job tile counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle job start pulse; honoured only in IDLE
- cfg_tiles  in  CNT_W  tiles in the job; sampled on start
- cfg_mode  in  1  0 = one ELEM_W lane per element; 1 = two independent ELEM_W/2 lanes; sampled on start
- in_valid  in  1  input tile valid
- in_ready  out  1  engine accepts a tile
- in_tile  in  16*ELEM_W  d(r,c) at bits [(4r+c)*ELEM_W +: ELEM_W], r = row 0..3, c = column 0..3
- out_valid  out  1  output tile valid
- out_ready  in  1  downstream accepts a tile
- out_tile  out  16*ELEM_W  V(r,c), same packing as in_tile
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse when the job's last tile leaves on the output handshake

## Operation
- FSM states are IDLE, RUN, DRAIN.
  - IDLE → RUN on start with cfg_tiles ≠ 0.
  - IDLE → DRAIN on start with cfg_tiles = 0; done pulses on the next cycle and the FSM returns to IDLE.
  - RUN → DRAIN on the input handshake of the last tile (accept count reaches cfg_tiles).
  - DRAIN → IDLE on the output handshake of the last tile; done pulses in that same cycle.
- start in RUN or DRAIN is ignored; latched cfg values are unchanged.
- Stage 1 (column transform), per column c, using row elements d0..d3:
  - t0 = d0 − d2
  - t1 = d1 + d2
  - t2 = d2 − d1
  - t3 = d1 − d3
- Stage 2 (row transform), the same equations applied along each row of t: v0 = t0 − t2, v1 = t1 + t2, v2 = t2 − t1, v3 = t1 − t3.
- Arithmetic is signed two's complement per lane.
  - mode 0: lane is ELEM_W bits.
  - mode 1: each element holds a low lane [ELEM_W/2−1:0] and a high lane, forming two tiles processed in parallel. No carry or borrow crosses a lane boundary.
- Every stage result is truncated (wrap) to lane width unless WINO_SAT_EN is defined.
- in_ready = (state == RUN) && (accepted < cfg_tiles) && (fifo_count + s1_valid < FIFO_DEPTH). The FIFO therefore never overflows, and stage 1 never stalls.
- out_valid = FIFO not empty; out_tile = FIFO head.
- The FIFO supports a simultaneous push and pop in the same cycle, including when it is full.

## Timing
- Input handshake at clock edge k → stage-1 register loaded at edge k → stage-2 result pushed into the FIFO at edge k+1. out_valid is high after edge k+1 when the FIFO was empty, giving a latency of 2 cycles.
- Throughput is 1 tile/cycle while out_ready is held high.
- out_tile is held stable while out_valid && !out_ready.
- Reset values: in_ready 0, out_valid 0, out_tile 0, busy 0, done 0, FSM = IDLE, counters 0, FIFO empty.
- Asynchronous reset mid-job flushes the pipeline and FIFO; in-flight tiles are discarded and no done is issued.
- Accept and emit counters are CNT_W bits wide; cfg_tiles = 2^CNT_W − 1 completes without wrapping.

## Configuration
- WINO_SAT_EN defined: each stage-1 and stage-2 result saturates per lane to [−2^(w−1), 2^(w−1)−1].
- WINO_SAT_EN undefined: results wrap modulo 2^w.
- Here w is the lane width: ELEM_W in mode 0, ELEM_W/2 in mode 1.

## Structure
- Shared package wino_pkg holds:
  - the FSM state enum (IDLE/RUN/DRAIN),
  - mode constants WINO_MODE_FULL = 0 and WINO_MODE_DUAL = 1,
  - the element index helper for (r,c) packing.
- Sub-module wino_lane_addsub: ELEM_W-wide add/sub with mode-controlled lane split and optional saturation, instantiated for every butterfly.
- The FIFO is inline.

## Test plan
- mode 0, ELEM_W = 16, one tile d = rows [1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16] → V rows [0,−16,0,0],[−4,34,2,−4],[0,8,0,0],[0,−16,0,0]; out_valid 2 cycles after acceptance; done pulses at the output handshake.
- mode 1: low lanes carry the tile above and high lanes carry all 0x7F → low-lane V as above. The high-lane results show no cross-lane carry disturbance, and no lane results differ from a single-lane model.
- 10-tile job with out_ready held low for 8 cycles → in_ready drops once FIFO_DEPTH tiles are in flight; all 10 tiles emerge in order and intact; exactly one done.
- d(1,*) = d(2,*) = 0x7FFF, other rows 0, mode 0 → V(1,1) = 0xFFFC without WINO_SAT_EN and 0x7FFF with it.
- start with cfg_tiles = 0 → no in_ready; done pulses one cycle later; busy high for that one cycle only.
- rst_n asserted after 3 of 6 tiles accepted → all outputs return to reset values immediately; no done; a following job runs correctly.
